pipe_scroller: RTL

//   Game-tick pipe mover feeding the pipe-pattern generator. Scrolls two pipes right-to-left.

---
 rtl/pipe_scroller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_scroller.sv
// Two-pipe scroller with game FSM and pass score.
// Moves pipes on each game tick and freezes per-pipe gap heights.
module pipe_scroller #(
  parameter int TICK_BIT = 16,
  parameter int SCREEN_W = 640,
  parameter int VIS_W    = 600,
  parameter int SPACING  = 320,
  parameter int SPEED    = 2,
  parameter int BIRD_X   = 100,
  parameter int END_MARK = 395
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [24:0] Clks,
  input  logic        Button,
  input  logic        Collision,
  input  logic [15:0] Pattern1,
  input  logic [15:0] Pattern2,
  output logic [15:0] PipesPosition1,
  output logic [15:0] PipesPosition2,
  output logic [15:0] Gap1,
  output logic [15:0] Gap2,
  output logic [7:0]  Score,
  output logic        Running,
  output logic        GameOver
);

  localparam logic [15:0] SW = 16'(SCREEN_W);
  localparam logic [15:0] VW = 16'(VIS_W);
  localparam logic [15:0] P2 = 16'(SCREEN_W + SPACING);
  localparam logic [15:0] SP = 16'(SPEED);
  localparam logic [15:0] BX = 16'(BIRD_X);
  localparam logic [15:0] EM = 16'(END_MARK);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        tb_q, tb_d;
  logic [15:0] pos1_q, pos1_d;
  logic [15:0] pos2_q, pos2_d;
  logic [15:0] gap1_q, gap1_d;
  logic [15:0] gap2_q, gap2_d;
  logic [7:0]  score_q, score_d;
  logic        run_q, over_q;
  logic        tick;
  logic [15:0] n1, n2, g1, g2;
  logic        x1, x2, e1, e2;
  logic [8:0]  sum;
  logic        unused_clks;

  assign unused_clks = ^Clks;

  function automatic logic [15:0] step(
    input logic [15:0] p
  );
    if (p == 16'd0)
      return SW;
    else if (p < SP)
      return 16'd0;
    else
      return p - SP;
  endfunction

  assign tb_d = Clks[TICK_BIT];
  assign tick = !tb_q && Clks[TICK_BIT];

  // next-position, gap capture, crossing and view-entry per pipe
  always_comb begin
    n1 = step(pos1_q);
    n2 = step(pos2_q);
    g1 = (pos1_q > VW) ? Pattern1 : gap1_q;
    g2 = (pos2_q > VW) ? Pattern2 : gap2_q;
    x1 = (pos1_q >= BX) && (n1 < BX);
    x2 = (pos2_q >= BX) && (n2 < BX);
    e1 = (pos1_q > VW) && (n1 <= VW)
      && (g1 == EM);
    e2 = (pos2_q > VW) && (n2 <= VW)
      && (g2 == EM);
    sum = {1'b0, score_q}
      + {8'd0, x1} + {8'd0, x2};
  end

  always_comb begin
    state_d = state_q;
    pos1_d  = pos1_q;
    pos2_d  = pos2_q;
    gap1_d  = gap1_q;
    gap2_d  = gap2_q;
    score_d = score_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!Button) state_d = RUN;
        end
        RUN: begin
          if (Collision) begin
            state_d = DEAD;
          end else begin
            pos1_d  = n1;
            pos2_d  = n2;
            gap1_d  = g1;
            gap2_d  = g2;
            score_d = sum[8] ? 8'hff : sum[7:0];
            if (e1 || e2) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      tb_q    <= tb_d;
      pos1_q  <= SW;
      pos2_q  <= P2;
      gap1_q  <= '0;
      gap2_q  <= '0;
      score_q <= '0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tb_q    <= tb_d;
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
      gap1_q  <= gap1_d;
      gap2_q  <= gap2_d;
      score_q <= score_d;
      run_q   <= (state_d == RUN);
      over_q  <= (state_d == DEAD)
        || (state_d == DONE);
    end
  end

  assign PipesPosition1 = pos1_q;
  assign PipesPosition2 = pos2_q;
  assign Gap1           = gap1_q;
  assign Gap2           = gap2_q;
  assign Score          = score_q;
  assign Running        = run_q;
  assign GameOver       = over_q;

endmodule
